// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin share of one APB master port
// between N_REQ req/gnt/rvalid requesters, with a pready watchdog.
module apb_master_arbiter #(
    parameter int N_REQ          = 2,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_REQ-1:0]                  req_i,
    input  logic [N_REQ*APB_ADDR_WIDTH-1:0]   addr_i,
    input  logic [N_REQ-1:0]                  we_i,
    input  logic [N_REQ*APB_DATA_WIDTH-1:0]   wdata_i,
    output logic [N_REQ-1:0]                  gnt_o,
    output logic [N_REQ-1:0]                  rvalid_o,
    output logic [APB_DATA_WIDTH-1:0]         rdata_o,
    output logic                              err_o,
    output logic [APB_ADDR_WIDTH-1:0]         paddr,
    output logic [APB_DATA_WIDTH-1:0]         pwdata,
    output logic                              pwrite,
    output logic                              psel,
    output logic                              penable,
    input  logic [APB_DATA_WIDTH-1:0]         prdata,
    input  logic                              pready,
    input  logic                              pslverr
);

    localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 0) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [LW-1:0] LAST_RST = LW'(N_REQ - 1);
    localparam logic [CW-1:0] CNT_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [LW-1:0] last;
    logic [LW-1:0] owner;
    logic [LW-1:0] win;
    logic [LW-1:0] cand;
    logic          any;
    logic [CW-1:0] cnt;
    logic          to_hit;
    logic          done;

    logic [APB_ADDR_WIDTH-1:0] addr_arr  [N_REQ];
    logic [APB_DATA_WIDTH-1:0] wdata_arr [N_REQ];

    // Unpack the flat per-requester buses into indexable arrays
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = addr_i[g*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
        assign wdata_arr[g] = wdata_i[g*APB_DATA_WIDTH +: APB_DATA_WIDTH];
    end

    // Round-robin search starting just after the last winner
    always_comb begin
        win  = '0;
        cand = '0;
        any  = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = LW'((int'(last) + k) % N_REQ);
            if (!any && req_i[cand]) begin
                any = 1'b1;
                win = cand;
            end
        end
    end

    // Watchdog fires on the last allowed wait cycle of ACCESS
    assign to_hit = TO_EN && (state == ACCESS) && !pready &&
                    (cnt == CNT_LAST);
    assign done   = (state == ACCESS) && (pready || to_hit);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Phase outputs and combinational grant
    always_comb begin
        psel    = 1'b0;
        penable = 1'b0;
        gnt_o   = '0;
        unique case (state)
            IDLE: begin
                if (any && !rst) gnt_o[win] = 1'b1;
            end
            SETUP: begin
                psel = 1'b1;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            default: begin
                psel    = 1'b0;
                penable = 1'b0;
            end
        endcase
    end

    // Request capture, pointer update, completion and watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            paddr    <= '0;
            pwdata   <= '0;
            pwrite   <= 1'b0;
            rvalid_o <= '0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
            last     <= LAST_RST;
            owner    <= '0;
            cnt      <= '0;
        end else begin
            rvalid_o <= '0;
            unique case (state)
                IDLE: begin
                    if (any) begin
                        paddr  <= addr_arr[win];
                        pwdata <= wdata_arr[win];
                        pwrite <= we_i[win];
                        owner  <= win;
                        last   <= win;
                    end
                end
                SETUP: begin
                    cnt <= '0;
                end
                ACCESS: begin
                    if (pready) begin
                        rvalid_o[owner] <= 1'b1;
                        rdata_o         <= pwrite ? '0 : prdata;
                        err_o           <= pslverr;
                    end else if (to_hit) begin
                        rvalid_o[owner] <= 1'b1;
                        rdata_o         <= '0;
                        err_o           <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed checks of grant order, APB phasing,
// wait states, slave error, watchdog timeout and mid-transfer reset.
module tb_apb_master_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [63:0] addr;
    logic [1:0]  we;
    logic [63:0] wdata;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int checks   = 0;
    int failures = 0;

    apb_master_arbiter #(
        .N_REQ          (2),
        .APB_ADDR_WIDTH (32),
        .APB_DATA_WIDTH (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req),
        .addr_i   (addr),
        .we_i     (we),
        .wdata_i  (wdata),
        .gnt_o    (gnt),
        .rvalid_o (rvalid),
        .rdata_o  (rdata),
        .err_o    (err),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pwrite   (pwrite),
        .psel     (psel),
        .penable  (penable),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = 2'b00; pready = 1'b0; pslverr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [1:0]  exp_g [4];
    logic [31:0] a0;
    logic [31:0] a1;

    initial begin
        rst = 1'b1; req = 2'b00; addr = '0; we = 2'b00; wdata = '0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;

        // Reset: no grant even with requests pending
        @(negedge clk);
        req = 2'b11;
        #1 chk("gnt_in_rst", gnt, 2'b00);
        @(negedge clk);
        rst = 1'b0; req = 2'b00;
        #1;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err", err, 0);

        // Single zero-wait read by requester 0
        addr[31:0] = 32'h1A10_3004; we = 2'b00; req = 2'b01;
        #1 chk("t1_gnt", gnt, 2'b01);
        @(negedge clk);
        req = 2'b00; pready = 1'b1; prdata = 32'hDEAD_BEEF;
        #1;
        chk("t1_setup_psel", psel, 1);
        chk("t1_setup_pen", penable, 0);
        chk("t1_paddr", paddr, 32'h1A10_3004);
        chk("t1_pwrite", pwrite, 0);
        @(negedge clk);
        #1;
        chk("t1_acc_psel", psel, 1);
        chk("t1_acc_pen", penable, 1);
        chk("t1_acc_rvalid", rvalid, 2'b00);
        @(negedge clk);
        pready = 1'b0;
        #1;
        chk("t1_rvalid", rvalid, 2'b01);
        chk("t1_rdata", rdata, 32'hDEAD_BEEF);
        chk("t1_err", err, 0);
        chk("t1_psel_off", psel, 0);

        // Both requesters held: grants alternate 0,1,0,1
        do_reset();
        a0 = 32'h1A10_0010; a1 = 32'h1A10_0020;
        addr = {a1, a0}; we = 2'b00; req = 2'b11;
        pready = 1'b1; prdata = 32'h1111_0000;
        exp_g[0] = 2'b01; exp_g[1] = 2'b10;
        exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        for (int t = 0; t < 4; t++) begin
            #1;
            chk("rr_gnt", gnt, exp_g[t]);
            chk("rr_idle_pen", penable, 0);
            if (t > 0) chk("rr_rvalid", rvalid, exp_g[t-1]);
            @(negedge clk);
            #1;
            chk("rr_setup_psel", psel, 1);
            chk("rr_setup_pen", penable, 0);
            chk("rr_paddr", paddr, (exp_g[t] == 2'b01) ? a0 : a1);
            @(negedge clk);
            #1;
            chk("rr_acc_psel", psel, 1);
            chk("rr_acc_pen", penable, 1);
            if (t == 3) req = 2'b00;
            @(negedge clk);
        end
        #1;
        chk("rr_last_rvalid", rvalid, 2'b10);
        chk("rr_no_gnt", gnt, 2'b00);

        // Write with three wait states
        addr[31:0] = 32'h1A10_2000; wdata[31:0] = 32'h0000_00A5;
        we = 2'b01; req = 2'b01; pready = 1'b0;
        #1 chk("w_gnt", gnt, 2'b01);
        @(negedge clk);
        req = 2'b00; we = 2'b00; wdata = '0; addr = '0;
        #1 chk("w_setup_psel", psel, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) begin
                pready = 1'b1; prdata = 32'h1234_5678;
            end
            #1;
            chk("w_acc_pen", penable, 1);
            chk("w_paddr", paddr, 32'h1A10_2000);
            chk("w_pwdata", pwdata, 32'h0000_00A5);
            chk("w_pwrite", pwrite, 1);
            chk("w_no_rvalid", rvalid, 2'b00);
        end
        @(negedge clk);
        pready = 1'b0;
        #1;
        chk("w_rvalid", rvalid, 2'b01);
        chk("w_rdata_zero", rdata, 0);
        chk("w_err", err, 0);
        chk("w_psel_off", psel, 0);
        chk("w_paddr_hold", paddr, 32'h1A10_2000);
        @(negedge clk);
        #1 chk("w_rvalid_once", rvalid, 2'b00);

        // Slave error on a read, then a clean read
        addr[63:32] = 32'h1A10_4000; req = 2'b10;
        #1 chk("e_gnt", gnt, 2'b10);
        @(negedge clk);
        req = 2'b00; pready = 1'b1; pslverr = 1'b1;
        prdata = 32'hCAFE_0001;
        @(negedge clk);
        #1 chk("e_acc_pen", penable, 1);
        @(negedge clk);
        addr[31:0] = 32'h1A10_5000; req = 2'b01;
        pslverr = 1'b0; prdata = 32'h0000_0042;
        #1;
        chk("e_rvalid", rvalid, 2'b10);
        chk("e_err", err, 1);
        chk("e_rdata", rdata, 32'hCAFE_0001);
        chk("e_next_gnt", gnt, 2'b01);
        @(negedge clk);
        req = 2'b00;
        #1;
        chk("e_err_hold", err, 1);
        chk("e_setup_psel", psel, 1);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("c_rvalid", rvalid, 2'b01);
        chk("c_err", err, 0);
        chk("c_rdata", rdata, 32'h0000_0042);

        // Watchdog timeout with requester 0 queued behind
        req = 2'b11; pready = 1'b0;
        #1 chk("to_gnt", gnt, 2'b10);
        @(negedge clk);
        req = 2'b01;
        #1 chk("to_setup_pen", penable, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("to_acc_psel", psel, 1);
            chk("to_acc_pen", penable, 1);
            chk("to_no_rvalid", rvalid, 2'b00);
        end
        @(negedge clk);
        #1;
        chk("to_psel_off", psel, 0);
        chk("to_rvalid", rvalid, 2'b10);
        chk("to_err", err, 1);
        chk("to_rdata", rdata, 0);
        chk("to_next_gnt", gnt, 2'b01);
        @(negedge clk);
        req = 2'b00; pready = 1'b1; prdata = 32'h0000_0055;
        #1 chk("to2_paddr", paddr, 32'h1A10_5000);
        @(negedge clk);
        @(negedge clk);
        pready = 1'b0;
        #1;
        chk("to2_rvalid", rvalid, 2'b01);
        chk("to2_err", err, 0);
        chk("to2_rdata", rdata, 32'h0000_0055);

        // Reset during ACCESS of requester 1
        req = 2'b10;
        #1 chk("r_gnt", gnt, 2'b10);
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        #1 chk("r_acc_pen", penable, 1);
        rst = 1'b1; req = 2'b11;
        @(negedge clk);
        #1;
        chk("r_psel", psel, 0);
        chk("r_pen", penable, 0);
        chk("r_rvalid", rvalid, 2'b00);
        chk("r_gnt_rst", gnt, 2'b00);
        rst = 1'b0;
        #1 chk("r_gnt_first", gnt, 2'b01);
        @(negedge clk);
        req = 2'b00;
        #1;
        chk("r_no_rvalid", rvalid, 2'b00);
        chk("r_setup_psel", psel, 1);
        chk("r_paddr", paddr, 32'h1A10_5000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
